// File: rtl/pat_seq_pkg.sv
// Shared definitions for the pattern sequencer: widths, the state encoding
// and the modular buffer-pointer increment.
package pat_seq_pkg;

   localparam int BUFFER_SIZE  = 32;
   localparam int BUFFER_WIDTH = 6;
   localparam int NUM_BUFFERS  = 8;
   localparam int BUFP_W       = $clog2(NUM_BUFFERS);
   localparam int FIELDP_W     = $clog2(BUFFER_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_BUF,
      ZERO_F,
      RUN,
      ADV_BUF,
      WR_SEEK,
      WR_STROBE,
      WR_RESTORE
   } state_t;

   function automatic logic [BUFP_W-1:0] ptr_next(input logic [BUFP_W-1:0] ptr);
      if (ptr == BUFP_W'(NUM_BUFFERS - 1)) return '0;
      return ptr + 1'b1;
   endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Connections between the pattern sequencer, the processor core, the serial
// loader and the buffers block; the sequencer uses the slave modport.
interface pattern_sequencer_if;
   import pat_seq_pkg::*;

   logic                    start;
   logic                    stop;
   logic                    step;
   logic [BUFP_W-1:0]       buf_first;
   logic [BUFP_W-1:0]       buf_last;
   logic [FIELDP_W-1:0]     field_last;
   logic                    ssel;
   logic [BUFP_W-1:0]       saddr;
   logic                    wr_req;
   logic [FIELDP_W-1:0]     wr_field;
   logic [BUFFER_WIDTH-1:0] wr_data;
   logic                    wr_ack;
   logic [BUFP_W-1:0]       bufp;
   logic [FIELDP_W-1:0]     fieldp;
   logic [BUFFER_WIDTH-1:0] field_in;
   logic                    field_write;
   logic                    busy;
   logic                    done;
   logic                    buf_wrap;

   modport master (
      output start, stop, step, buf_first, buf_last, field_last, ssel, saddr,
             wr_req, wr_field, wr_data,
      input  wr_ack, bufp, fieldp, field_in, field_write, busy, done, buf_wrap
   );

   modport slave (
      input  start, stop, step, buf_first, buf_last, field_last, ssel, saddr,
             wr_req, wr_field, wr_data,
      output wr_ack, bufp, fieldp, field_in, field_write, busy, done, buf_wrap
   );

endinterface

// File: rtl/pat_seq_write_unit.sv
// Field-write sequencer: borrows fieldp for one strobe and then restores it.
// Started by a go pulse; ret marks the final cycle, after which the caller resumes.
module pat_seq_write_unit
   import pat_seq_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    go,
   input  logic [FIELDP_W-1:0]     fieldp,
   input  logic [FIELDP_W-1:0]     wr_field,
   input  logic [BUFFER_WIDTH-1:0] wr_data,
   output logic                    busy,
   output logic                    ret,
   output logic                    fieldp_load,
   output logic [FIELDP_W-1:0]     fieldp_val,
   output logic [BUFFER_WIDTH-1:0] field_in,
   output logic                    field_write,
   output logic                    wr_ack
);

   state_t              wstate, wstate_next;
   logic [FIELDP_W-1:0] saved_fieldp;

   always_comb begin
      wstate_next = wstate;
      unique case (wstate)
         IDLE:       if (go) wstate_next = WR_SEEK;
         WR_SEEK:    wstate_next = WR_STROBE;
         WR_STROBE:  wstate_next = WR_RESTORE;
         WR_RESTORE: wstate_next = IDLE;
         default:    wstate_next = IDLE;
      endcase
   end

   assign busy        = (wstate != IDLE);
   assign ret         = (wstate == WR_RESTORE);
   assign fieldp_load = (wstate == WR_SEEK) || (wstate == WR_RESTORE);
   assign fieldp_val  = (wstate == WR_SEEK) ? wr_field : saved_fieldp;

   // Reset drops a write in flight without acknowledging it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wstate       <= IDLE;
         saved_fieldp <= '0;
         field_in     <= '0;
         field_write  <= 1'b0;
         wr_ack       <= 1'b0;
      end else begin
         wstate      <= wstate_next;
         field_write <= (wstate == WR_STROBE);
         wr_ack      <= (wstate == WR_RESTORE);
         if (wstate == WR_SEEK) begin
            saved_fieldp <= fieldp;
            field_in     <= wr_data;
         end
      end
   end

endmodule

// File: rtl/pattern_sequencer.sv
// Pattern sequencer top: steps fieldp through each buffer and bufp over a range.
// Define PATSEQ_LOOP_EN to wrap the range continuously instead of finishing with done.
module pattern_sequencer
   import pat_seq_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   pattern_sequencer_if.slave bus
);

   state_t                  state, state_next;
   logic [BUFP_W-1:0]       bufp, bufp_nxt, bufp_src;
   logic [FIELDP_W-1:0]     fieldp;
   logic                    busy, done, stop_pend;
   logic                    bufp_load, fieldp_clr, fieldp_inc, done_set;
   logic                    run_active, wr_accept, at_last, ssel_hit;
   logic                    wr_go, wr_busy, wr_ret, wr_fieldp_load, wr_ack, field_write;
   logic [FIELDP_W-1:0]     wr_fieldp_val;
   logic [BUFFER_WIDTH-1:0] field_in;
`ifdef PATSEQ_LOOP_EN
   logic                    wrap_set, buf_wrap;
`endif

   // The main FSM freezes while the write unit runs, so its state is the return point.
   assign run_active = (state == RUN) && !wr_busy;
   assign wr_accept  = bus.wr_req && !wr_ack;
   assign at_last    = (bufp == bus.buf_last);
   assign bufp_nxt   = at_last ? bus.buf_first : ptr_next(bufp);
   assign ssel_hit   = bus.ssel && (bus.saddr == bufp_nxt);

   always_comb begin
      state_next = state;
      wr_go      = 1'b0;
      bufp_load  = 1'b0;
      bufp_src   = bufp_nxt;
      fieldp_clr = 1'b0;
      fieldp_inc = 1'b0;
      done_set   = 1'b0;
`ifdef PATSEQ_LOOP_EN
      wrap_set   = 1'b0;
`endif
      if (!wr_busy) begin
         unique case (state)
            IDLE: begin
               if (wr_accept)      wr_go = 1'b1;
               else if (bus.start) state_next = LOAD_BUF;
            end
            LOAD_BUF: begin
               bufp_load  = 1'b1;
               bufp_src   = bus.buf_first;
               state_next = ZERO_F;
            end
            ZERO_F: begin
               fieldp_clr = 1'b1;
               state_next = RUN;
            end
            RUN: begin
               if (bus.stop || stop_pend)         state_next = IDLE;
               else if (wr_accept)                wr_go = 1'b1;
               else if (bus.step) begin
                  if (fieldp < bus.field_last)    fieldp_inc = 1'b1;
                  else                            state_next = ADV_BUF;
               end
            end
            ADV_BUF: begin
`ifdef PATSEQ_LOOP_EN
               if (!ssel_hit) begin
                  bufp_load  = 1'b1;
                  wrap_set   = at_last;
                  state_next = ZERO_F;
               end
`else
               if (at_last) begin
                  done_set   = 1'b1;
                  state_next = IDLE;
               end else if (!ssel_hit) begin
                  bufp_load  = 1'b1;
                  state_next = ZERO_F;
               end
`endif
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         bufp      <= '0;
         fieldp    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         stop_pend <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE) || wr_go || (wr_busy && !wr_ret);
         done  <= done_set;
         if (bufp_load) bufp <= bufp_src;
         if (wr_fieldp_load)  fieldp <= wr_fieldp_val;
         else if (fieldp_clr) fieldp <= '0;
         else if (fieldp_inc) fieldp <= fieldp + 1'b1;
         if (run_active)      stop_pend <= 1'b0;
         else if (bus.stop)   stop_pend <= 1'b1;
      end
   end

`ifdef PATSEQ_LOOP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) buf_wrap <= 1'b0;
      else        buf_wrap <= wrap_set;
   end
   assign bus.buf_wrap = buf_wrap;
`else
   assign bus.buf_wrap = 1'b0;
`endif

   pat_seq_write_unit u_write (
      .clk         (clk),
      .rst_n       (rst_n),
      .go          (wr_go),
      .fieldp      (fieldp),
      .wr_field    (bus.wr_field),
      .wr_data     (bus.wr_data),
      .busy        (wr_busy),
      .ret         (wr_ret),
      .fieldp_load (wr_fieldp_load),
      .fieldp_val  (wr_fieldp_val),
      .field_in    (field_in),
      .field_write (field_write),
      .wr_ack      (wr_ack)
   );

   assign bus.bufp        = bufp;
   assign bus.fieldp      = fieldp;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.wr_ack      = wr_ack;
   assign bus.field_in    = field_in;
   assign bus.field_write = field_write;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer; a scoreboard holds the expected {bufp,fieldp} sequence.
// With PATSEQ_LOOP_EN defined the wrapping range replaces the finishing range scenario.
module tb_pattern_sequencer;
   import pat_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst_at_edge = 1'b0;
   int         pass_cnt = 0;
   int         total_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] prev_ptr = '0;
   logic [7:0] cur_ptr;
   logic [4:0] last_f;
   logic       found;
   logic       done_seen;

   pattern_sequencer_if bus();

   pattern_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total_cnt++;
      assert (observed === expected) pass_cnt++;
      else $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pushPtr(input logic [2:0] b, input logic [4:0] f);
      exp_q.push_back({b, f});
   endtask

   // Programs the range and step level, then pulses start for one cycle.
   task automatic applyStimulus(input logic [2:0] first, input logic [2:0] last,
                                input logic [4:0] flast, input logic stp);
      bus.buf_first  = first;
      bus.buf_last   = last;
      bus.field_last = flast;
      bus.step       = stp;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start      = 1'b0;
   endtask

   // Every pointer change is popped against the scoreboard and must move only one pointer.
   always @(posedge clk) rst_at_edge <= rst_n;

   always @(negedge clk) begin
      cur_ptr = {bus.bufp, bus.fieldp};
      if (rst_at_edge && cur_ptr != prev_ptr) begin
         checkOutput("ptr_one_at_a_time",
                     32'((cur_ptr[7:5] != prev_ptr[7:5]) && (cur_ptr[4:0] != prev_ptr[4:0])), 0);
         if (exp_q.size() == 0) checkOutput("ptr_seq_extra", 32'(cur_ptr), 32'(prev_ptr));
         else                   checkOutput("ptr_seq", 32'(cur_ptr), 32'(exp_q.pop_front()));
      end
      prev_ptr = cur_ptr;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.start = 0; bus.stop = 0; bus.step = 0;
      bus.buf_first = 0; bus.buf_last = 0; bus.field_last = 0;
      bus.ssel = 0; bus.saddr = 0;
      bus.wr_req = 0; bus.wr_field = 0; bus.wr_data = 0;
      rst_n = 1'b0;
      waitNeg(2);
      checkOutput("rst_bufp", 32'(bus.bufp), 0);
      checkOutput("rst_fieldp", 32'(bus.fieldp), 0);
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_done", 32'(bus.done), 0);
      checkOutput("rst_wr_ack", 32'(bus.wr_ack), 0);
      checkOutput("rst_field_write", 32'(bus.field_write), 0);
      checkOutput("rst_field_in", 32'(bus.field_in), 0);
      checkOutput("rst_buf_wrap", 32'(bus.buf_wrap), 0);
      rst_n = 1'b1;
      waitNeg(1);

`ifdef PATSEQ_LOOP_EN
      $display("[TB] wrapping range 6..1");
      pushPtr(6, 0); pushPtr(7, 0); pushPtr(0, 0); pushPtr(1, 0); pushPtr(6, 0);
      applyStimulus(3'd6, 3'd1, 5'd0, 1'b1);
      found = 0; done_seen = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (bus.done) done_seen = 1;
         if (bus.buf_wrap) found = 1;
      end
      checkOutput("loop_wrap_seen", 32'(found), 1);
      checkOutput("loop_wrap_bufp", 32'(bus.bufp), 6);
      bus.stop = 1;
      waitNeg(1);
      bus.stop = 0;
      checkOutput("loop_wrap_pulse", 32'(bus.buf_wrap), 0);
      waitNeg(1);
      checkOutput("loop_stop_idle", 32'(bus.busy), 0);
      checkOutput("loop_no_done", 32'(done_seen), 0);
      bus.step = 0;
      last_f = 5'd0;
`else
      $display("[TB] range 2..3, four fields, no loop");
      pushPtr(2, 0); pushPtr(2, 1); pushPtr(2, 2); pushPtr(2, 3);
      pushPtr(3, 3); pushPtr(3, 0); pushPtr(3, 1); pushPtr(3, 2); pushPtr(3, 3);
      applyStimulus(3'd2, 3'd3, 5'd3, 1'b1);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (bus.done) found = 1;
      end
      checkOutput("range_done_seen", 32'(found), 1);
      checkOutput("range_done_bufp", 32'(bus.bufp), 3);
      checkOutput("range_done_fieldp", 32'(bus.fieldp), 3);
      checkOutput("range_done_busy", 32'(bus.busy), 0);
      checkOutput("range_no_wrap", 32'(bus.buf_wrap), 0);
      bus.step = 0;
      waitNeg(1);
      checkOutput("range_done_pulse", 32'(bus.done), 0);
      last_f = 5'd3;
`endif

      $display("[TB] write during RUN");
      if (last_f != 0) pushPtr(1, last_f);
      pushPtr(1, 0);
      applyStimulus(3'd1, 3'd1, 5'd20, 1'b0);
      waitNeg(2);
      checkOutput("run_start_fieldp", 32'(bus.fieldp), 0);
      for (int f = 1; f <= 5; f++) pushPtr(1, 5'(f));
      bus.step = 1;
      waitNeg(5);
      checkOutput("run_fieldp5", 32'(bus.fieldp), 5);
      bus.step = 0; bus.wr_req = 1; bus.wr_field = 5'd17; bus.wr_data = 6'h2A;
      pushPtr(1, 17); pushPtr(1, 5); pushPtr(1, 6);
      waitNeg(1);
      checkOutput("wr_seek_fieldp", 32'(bus.fieldp), 5);
      checkOutput("wr_seek_busy", 32'(bus.busy), 1);
      waitNeg(1);
      checkOutput("wr_fieldp17", 32'(bus.fieldp), 17);
      checkOutput("wr_no_early_strobe", 32'(bus.field_write), 0);
      waitNeg(1);
      checkOutput("wr_strobe", 32'(bus.field_write), 1);
      checkOutput("wr_field_in", 32'(bus.field_in), 32'h2A);
      checkOutput("wr_strobe_fieldp", 32'(bus.fieldp), 17);
      waitNeg(1);
      checkOutput("wr_ack", 32'(bus.wr_ack), 1);
      checkOutput("wr_restore_fieldp", 32'(bus.fieldp), 5);
      checkOutput("wr_strobe_single", 32'(bus.field_write), 0);
      bus.step = 1;
      waitNeg(1);
      checkOutput("wr_ack_pulse", 32'(bus.wr_ack), 0);
      checkOutput("wr_resume_fieldp", 32'(bus.fieldp), 6);
      bus.wr_req = 0; bus.step = 0; bus.stop = 1;
      waitNeg(1);
      bus.stop = 0;
      checkOutput("run_stop_idle", 32'(bus.busy), 0);

      $display("[TB] serial-load stall");
      pushPtr(3, 6); pushPtr(3, 0); pushPtr(4, 0);
      bus.ssel = 1; bus.saddr = 3'd4;
      applyStimulus(3'd3, 3'd5, 5'd0, 1'b1);
      waitNeg(4);
      checkOutput("stall_bufp", 32'(bus.bufp), 3);
      checkOutput("stall_busy", 32'(bus.busy), 1);
      waitNeg(3);
      checkOutput("stall_hold_bufp", 32'(bus.bufp), 3);
      bus.ssel = 0;
      waitNeg(1);
      checkOutput("stall_release_bufp", 32'(bus.bufp), 4);
      bus.stop = 1;
      waitNeg(1);
      bus.stop = 0;
      checkOutput("stop_latched_busy", 32'(bus.busy), 1);
      waitNeg(1);
      checkOutput("stop_latched_idle", 32'(bus.busy), 0);
      bus.step = 0;

      $display("[TB] start and wr_req together in IDLE");
      pushPtr(4, 9); pushPtr(4, 0);
      bus.start = 1; bus.wr_req = 1; bus.wr_field = 5'd9; bus.wr_data = 6'h15;
      waitNeg(1);
      bus.start = 0;
      checkOutput("both_busy", 32'(bus.busy), 1);
      waitNeg(1);
      checkOutput("both_fieldp9", 32'(bus.fieldp), 9);
      waitNeg(1);
      checkOutput("both_strobe", 32'(bus.field_write), 1);
      checkOutput("both_field_in", 32'(bus.field_in), 32'h15);
      waitNeg(1);
      checkOutput("both_ack", 32'(bus.wr_ack), 1);
      checkOutput("both_ack_idle", 32'(bus.busy), 0);
      waitNeg(1);
      bus.wr_req = 0;
      checkOutput("both_start_dropped", 32'(bus.busy), 0);
      checkOutput("both_bufp_kept", 32'(bus.bufp), 4);

      $display("[TB] stop during write");
      pushPtr(0, 0); pushPtr(0, 2); pushPtr(0, 0);
      applyStimulus(3'd0, 3'd0, 5'd7, 1'b0);
      waitNeg(2);
      bus.wr_req = 1; bus.wr_field = 5'd2; bus.wr_data = 6'h01;
      waitNeg(2);
      checkOutput("wstop_fieldp2", 32'(bus.fieldp), 2);
      bus.stop = 1;
      waitNeg(1);
      bus.stop = 0;
      checkOutput("wstop_strobe", 32'(bus.field_write), 1);
      waitNeg(1);
      checkOutput("wstop_ack", 32'(bus.wr_ack), 1);
      checkOutput("wstop_busy_on_ack", 32'(bus.busy), 1);
      waitNeg(1);
      bus.wr_req = 0;
      checkOutput("wstop_idle", 32'(bus.busy), 0);

      $display("[TB] reset mid-write");
      pushPtr(0, 11);
      bus.wr_req = 1; bus.wr_field = 5'd11; bus.wr_data = 6'h3F;
      waitNeg(2);
      checkOutput("rstw_fieldp11", 32'(bus.fieldp), 11);
      waitNeg(1);
      checkOutput("rstw_strobe", 32'(bus.field_write), 1);
      rst_n = 1'b0;
      waitNeg(1);
      checkOutput("rstw_field_write", 32'(bus.field_write), 0);
      checkOutput("rstw_fieldp", 32'(bus.fieldp), 0);
      checkOutput("rstw_bufp", 32'(bus.bufp), 0);
      checkOutput("rstw_wr_ack", 32'(bus.wr_ack), 0);
      rst_n = 1'b1; bus.wr_req = 0;
      waitNeg(1);
      checkOutput("rstw_no_late_ack", 32'(bus.wr_ack), 0);
      checkOutput("rstw_idle", 32'(bus.busy), 0);

      waitNeg(2);
      checkOutput("sb_empty", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
